// File: rtl/lm32_irq_filter.sv
// Conditions raw interrupt sources for the LM32 core: synchronise, normalise
// polarity, glitch-filter, then shape as level or rising-edge pulse.
module lm32_irq_filter #(
  parameter int          CFG_INTERRUPTS = 32,
  parameter int          INTERRUPTS     = CFG_INTERRUPTS,
  parameter int          SYNC_STAGES    = 2,
  parameter int          FILTER_CYCLES  = 2,
  parameter logic [31:0] EDGE_MASK      = '0,
  parameter logic [31:0] POL_MASK       = '1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INTERRUPTS-1:0] irq_i,
  input  logic [INTERRUPTS-1:0] irq_en_i,
  output logic [INTERRUPTS-1:0] interrupt_n,
  output logic [INTERRUPTS-1:0] irq_level_o
);

  localparam int                    CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0]         CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [INTERRUPTS-1:0] EDGE     = EDGE_MASK[INTERRUPTS-1:0];
  localparam logic [INTERRUPTS-1:0] POL      = POL_MASK[INTERRUPTS-1:0];

  logic [INTERRUPTS-1:0] norm;
  logic [INTERRUPTS-1:0] sync_q [SYNC_STAGES];
  logic [INTERRUPTS-1:0] s;
  logic [CW-1:0]         cnt_q  [INTERRUPTS];
  logic [INTERRUPTS-1:0] filt_q;
  logic [INTERRUPTS-1:0] filt_d_q;
  logic [INTERRUPTS-1:0] int_n_q;
  logic [INTERRUPTS-1:0] active;

  // Inverting active-low sources before the synchroniser keeps the chain's
  // reset value (0) meaning "not asserted" for every source.
  assign norm = irq_i ^ ~POL;
  assign s    = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= norm;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= '0;
      for (int unsigned i = 0; i < INTERRUPTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < INTERRUPTS; i++) begin
        if (s[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_q[i] <= s[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    active = irq_en_i & filt_q & (~EDGE | ~filt_d_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_d_q <= '0;
      int_n_q  <= '1;
    end else begin
      filt_d_q <= filt_q;
      int_n_q  <= ~active;
    end
  end

  assign interrupt_n = int_n_q;
  assign irq_level_o = filt_q;

endmodule

// File: tb/tb_lm32_irq_filter.sv
// Scoreboard bench for lm32_irq_filter: a sliding-window reference model
// predicts outputs per clock edge; a monitor compares on the falling edge.
module tb_lm32_irq_filter;
  localparam int          N    = 32;
  localparam int          SS   = 2;
  localparam int          FC   = 2;
  localparam logic [31:0] EDGE = 32'h0000_0104;
  localparam logic [31:0] POL  = 32'hFFFF_FFEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  irq;
  logic [N-1:0]  en;
  logic [N-1:0]  int_n;
  logic [N-1:0]  lvl;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lm32_irq_filter #(
    .CFG_INTERRUPTS(N),
    .INTERRUPTS    (N),
    .SYNC_STAGES   (SS),
    .FILTER_CYCLES (FC),
    .EDGE_MASK     (EDGE),
    .POL_MASK      (POL)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .irq_i      (irq),
    .irq_en_i   (en),
    .interrupt_n(int_n),
    .irq_level_o(lvl)
  );

  typedef struct packed {
    logic [31:0] n;
    logic [31:0] l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hist[$];
  logic [31:0] mf  = '0;
  logic [31:0] mfd = '0;

  initial for (int j = 0; j < SS + FC; j++) hist.push_back('0);

  // Reference: filtered level flips once the FC most recent synchronised
  // samples (delayed SS edges) all disagree with it.
  always @(posedge clk) begin : model
    logic [31:0] a, flip, expn;
    exp_t e;
    if (rst) begin
      foreach (hist[j]) hist[j] = '0;
      mf  = '0;
      mfd = '0;
      e.n = 32'hFFFF_FFFF;
      e.l = '0;
      sb.push_back(e);
    end else begin
      a = irq ^ ~POL;
      hist.push_front(a);
      expn = ~(en & mf & (~EDGE | ~mfd));
      flip = 32'hFFFF_FFFF;
      for (int j = SS; j < SS + FC; j++) flip &= hist[j] ^ mf;
      void'(hist.pop_back());
      mfd = mf;
      mf  = mf ^ flip;
      e.n = expn;
      e.l = mf;
      sb.push_back(e);
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (int_n !== e.n) begin
        errors++;
        $display("FAIL sb_interrupt_n t=%0t got=%h expected=%h", $time, int_n, e.n);
      end
      checks++;
      if (lvl !== e.l) begin
        errors++;
        $display("FAIL sb_irq_level t=%0t got=%h expected=%h", $time, lvl, e.l);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int pulses;
    irq = 32'h0000_0010;
    en  = '1;
    step(3);
    chk("reset_int_n", int_n, 32'hFFFF_FFFF);
    chk("reset_level", lvl, 32'h0);
    rst = 1'b0;
    step(10);

    irq[0] = 1'b1;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (int_n[0] == 1'b0) begin lat = c; break; end
    end
    chk("level_assert_latency", 32'(lat), 32'd5);
    step(10);
    irq[0] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (int_n[0] == 1'b1) begin lat = c; break; end
    end
    chk("level_release_latency", 32'(lat), 32'd5);

    irq[1] = 1'b1; step(1); irq[1] = 1'b0; step(10);
    irq[1] = 1'b1; step(2); irq[1] = 1'b0; step(10);

    irq[2] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (int_n[2] == 1'b0) pulses++;
    end
    chk("edge_single_pulse", 32'(pulses), 32'd1);
    irq[2] = 1'b0; step(3);
    irq[2] = 1'b1; step(10);
    irq[2] = 1'b0; step(5);

    irq[4] = 1'b0; step(10);
    irq[4] = 1'b1; step(10);

    en[5] = 1'b0; irq[5] = 1'b1; step(8);
    chk("gated_int_n5", {31'b0, int_n[5]}, 32'd1);
    chk("gated_level5", {31'b0, lvl[5]}, 32'd1);
    en[5] = 1'b1; @(negedge clk);
    chk("enable_rise_int_n5", {31'b0, int_n[5]}, 32'd0);
    irq[5] = 1'b0; step(8);

    en[2] = 1'b0; irq[2] = 1'b1; step(8);
    en[2] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (int_n[2] == 1'b0) pulses++;
    end
    chk("lost_edge_pulse", 32'(pulses), 32'd0);
    irq[2] = 1'b0; step(5);

    irq[3] = 1'b1; step(8);
    chk("pre_reset_int_n3", {31'b0, int_n[3]}, 32'd0);
    #1 rst = 1'b1;
    #1 chk("async_reset_int_n3", {31'b0, int_n[3]}, 32'd1);
    chk("async_reset_level", lvl, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(10);
    irq[3] = 1'b0; step(8);

    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      irq ^= $urandom & $urandom & $urandom;
      en  ^= $urandom & $urandom & $urandom & $urandom & $urandom;
    end
    step(3);
    #2 chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lm32_irq_filter.md
# lm32_irq_filter

Conditions raw external interrupt sources before they reach the LM32 core's interrupt pins. Each source passes through a multi-flop synchroniser, a polarity normaliser, a per-source glitch filter and a level/edge shaper. The block drives the core's active-low `interrupt_n` vector, which the core latches into its IP CSR. It sits between SoC peripherals/pads and the CPU top-level.

## Interface
Parameters:
- `INTERRUPTS`, `CFG_INTERRUPTS` (32): number of sources, 1..32.
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `FILTER_CYCLES`, 2: consecutive mismatching samples needed to change the filtered level, 1..255.
- `EDGE_MASK`, 0: bit i=1 makes source i rising-edge (pulse) type; 0 makes it level type.
- `POL_MASK`, all ones: bit i=1 means `irq_i[i]` is active-high; 0 means active-low.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `irq_i` in INTERRUPTS: raw sources, asynchronous to `clk_i`.
- `irq_en_i` in INTERRUPTS: per-source enable, synchronous to `clk_i`.
- `interrupt_n` out INTERRUPTS: to core, active-low, registered.
- `irq_level_o` out INTERRUPTS: filtered, normalised (1 = asserted) level, registered, for status readback.

## Operation
- Normalise per source: `a[i] = POL_MASK[i] ? irq_i[i] : ~irq_i[i]`. This value feeds the synchroniser chain. `s[i]` is the chain's last stage.
- Filter, per source: counter `cnt` of width ceil(log2(FILTER_CYCLES+1)) and filtered level `f` (= `irq_level_o`).
  - On each edge where `s == f`: `cnt <= 0`.
  - Otherwise, if `cnt == FILTER_CYCLES-1`: `f <= s`, `cnt <= 0`. Else `cnt <= cnt+1`.
  - A mismatch lasting fewer than FILTER_CYCLES samples is discarded completely; the counter restarts from 0 on the next mismatch.
- Delayed copy `f_d <= f` every cycle.
- Level source: `interrupt_n[i] <= ~(irq_en_i[i] & f[i])`.
- Edge source: `interrupt_n[i] <= ~(irq_en_i[i] & f[i] & ~f_d[i])`, giving exactly one low cycle per filtered rising edge. Falling edges produce nothing.
- Enable gating:
  - Applied at the output register only; the filter keeps running while disabled.
  - An edge whose pulse cycle falls while `irq_en_i=0` is lost, not buffered.
  - A level source that is asserted when enable rises asserts `interrupt_n` on the next edge.
- Reset values, all asynchronous: sync chain 0, `cnt` 0, `f` 0, `f_d` 0, `irq_level_o` 0, `interrupt_n` all ones. Reset asserted mid-filter or mid-pulse forces these values immediately. The first post-reset evaluation treats a held-asserted input as a fresh rising edge, so an edge source pulses once.
- Sources are fully independent; simultaneous events on any set of sources are each handled in the same cycle.

## Timing
- Input stable before edge k is captured in stage 1 at edge k and appears on `s` after edge k+SYNC_STAGES-1.
- `f`/`irq_level_o` updates at edge k+SYNC_STAGES-1+FILTER_CYCLES.
- `interrupt_n` updates at edge k+SYNC_STAGES+FILTER_CYCLES. Defaults give 5 edges; deassertion has the same latency.
- Edge pulse is low for exactly 1 cycle, starting at the same edge the level output would assert.
- Minimum accepted input pulse: SYNC_STAGES-independent, FILTER_CYCLES consecutive samples high. Back-to-back accepted edges need ≥FILTER_CYCLES samples low between them.
- `irq_en_i` to `interrupt_n`: 1 edge.
- No combinational path from any input to any output.

## Test plan
- Reset release with all sources idle (POL default) -> `interrupt_n`=0xFFFFFFFF and `irq_level_o`=0 at every edge. Assert `rst_i` mid-test while `interrupt_n[3]`=0 -> `interrupt_n[3]`=1 before the next clock edge.
- Level source 0, defaults, `irq_en_i[0]`=1: raise `irq_i[0]` before edge 10 -> `irq_level_o[0]`=1 after edge 13 and `interrupt_n[0]`=0 after edge 14. Drop before edge 20 -> `interrupt_n[0]`=1 after edge 24.
- Glitch rejection, FILTER_CYCLES=2: hold `irq_i[1]` high for 1 cycle -> `irq_level_o[1]` and `interrupt_n[1]` never change and `cnt` returns to 0. Hold for 2 cycles -> assert.
- Edge source 2 (EDGE_MASK=0x4): hold `irq_i[2]` high for 50 cycles -> `interrupt_n[2]` low for exactly 1 cycle, at latency 5. A second rise after ≥2 low samples -> second single-cycle pulse.
- Active-low source 4 (POL_MASK bit 4=0): drive `irq_i[4]`=0 -> `interrupt_n[4]`=0 after 5 edges. Drive `irq_i[4]`=1 -> released after 5 edges.
- Enable gating with source 5 asserted level and `irq_en_i[5]`=0 -> `interrupt_n[5]`=1 and `irq_level_o[5]`=1. Set enable -> `interrupt_n[5]`=0 one edge later. An edge-source pulse while disabled -> no pulse after re-enable.
